// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg
// Shared types and constants for the LCD control-bus sequencer.
//   seqState_t  : sequencer state encoding (also exposed on the debug port)
//   SEL_SETUP   : control-mux select for the LCD set-up controller
//   SEL_CHARGEN : control-mux select for the character generator
// The select constants are also used by the control mux itself, so keep the
// encodings stable.
package lcd_seq_pkg;

  typedef enum logic [2:0] {
    POWERUP = 3'd0,
    SETUP   = 3'd1,
    READY   = 3'd2,
    GRANT   = 3'd3,
    GAP     = 3'd4
  } seqState_t;

  localparam logic [1:0] SEL_SETUP   = 2'd0;
  localparam logic [1:0] SEL_CHARGEN = 2'd1;

endpackage

// File: rtl/lcd_ctrl_sequencer_if.sv
// lcd_ctrl_sequencer_if
// Bundles the sequencer's handshakes with the set-up controller, the
// character generator and the top level.
//   setUpDone    : set-up controller finished (pulse or level)
//   charGenReq   : char generator wants the bus (level)
//   charGenDone  : char generator finished its current command
//   reInit       : request to rerun the LCD set-up sequence
//   ctrlSel      : control-mux select (SEL_SETUP / SEL_CHARGEN)
//   setUpStart   : one-cycle start pulse to the set-up controller
//   charGenGrant : char generator owns the bus (level)
//   ready        : sequencer idle, LCD initialised, bus available
//   timeoutErr   : sticky watchdog error (LCD_SEQ_TIMEOUT_EN builds only)
// modport master : the sequencer side; modport slave : the sources / top level.
//
// Handshake semantics: charGenReq is a level the char generator holds until it
// sees charGenGrant; charGenGrant then stays high until the sequencer samples
// charGenDone, and drops the following cycle. setUpStart is a single-cycle
// pulse; setUpDone is only looked at while set-up is running, so either a
// pulse or a held level completes it.
interface lcd_ctrl_sequencer_if;

  logic       setUpDone;
  logic       charGenReq;
  logic       charGenDone;
  logic       reInit;
  logic [1:0] ctrlSel;
  logic       setUpStart;
  logic       charGenGrant;
  logic       ready;
`ifdef LCD_SEQ_TIMEOUT_EN
  logic       timeoutErr;
`endif

  modport master (
    input  setUpDone,
    input  charGenReq,
    input  charGenDone,
    input  reInit,
    output ctrlSel,
    output setUpStart,
    output charGenGrant,
    output ready
`ifdef LCD_SEQ_TIMEOUT_EN
    , output timeoutErr
`endif
  );

  modport slave (
    output setUpDone,
    output charGenReq,
    output charGenDone,
    output reInit,
    input  ctrlSel,
    input  setUpStart,
    input  charGenGrant,
    input  ready
`ifdef LCD_SEQ_TIMEOUT_EN
    , input timeoutErr
`endif
  );

endinterface

// File: rtl/lcd_seq_delay_cnt.sv
// lcd_seq_delay_cnt
// Up-counter with synchronous clear and an expire flag, shared by the
// power-up wait, the inter-command gap and the watchdog.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : reload the count to zero (takes priority over en)
//   en       : count this cycle
//   limit    : expire threshold
//   expired  : count has reached limit
// The count saturates once it reaches limit, so a long wait never wraps back
// below the threshold.
module lcd_seq_delay_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  assign expired = (count >= limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/lcd_ctrl_sequencer.sv
// lcd_ctrl_sequencer
// Owns the LCD control-bus mux select. After reset it waits POWERUP_CYCLES,
// runs the set-up controller once, then grants the bus to the character
// generator one command at a time with a GAP_CYCLES settle gap after each.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : lcd_ctrl_sequencer_if.master (handshakes, ctrlSel, ready)
//   dbgState : current FSM state, for observation only
// Optional feature: define LCD_SEQ_TIMEOUT_EN to add TIMEOUT_CYCLES, the
// watchdog on SETUP/GRANT and the sticky bus.timeoutErr output. A watchdog
// expiry restarts the whole sequence from POWERUP.
module lcd_ctrl_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int POWERUP_CYCLES = 750000,
  parameter int GAP_CYCLES     = 2500
`ifdef LCD_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  lcd_ctrl_sequencer_if.master        bus,
  output seqState_t                   dbgState
);

`ifdef LCD_SEQ_TIMEOUT_EN
  localparam int WD_CYCLES = TIMEOUT_CYCLES;
`else
  localparam int WD_CYCLES = 0;
`endif
  localparam int MAX_PG     = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
  localparam int MAX_CYCLES = (MAX_PG > WD_CYCLES) ? MAX_PG : WD_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  // The counter reads 0 in the first cycle of a state. POWERUP leaves when it
  // reads POWERUP_CYCLES (reset itself counts as the first power-up cycle);
  // GAP leaves in its last cycle, so a zero-length gap still lasts one cycle.
  localparam logic [CNT_W-1:0] PWR_LIM = CNT_W'(POWERUP_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LIM = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
`ifdef LCD_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LIM  = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  seqState_t        state;
  seqState_t        nextState;
  logic             pendReInit;
  logic             setPend;
  logic             clrPend;
  logic             cntEn;
  logic             cntExpired;
  logic [CNT_W-1:0] cntLimit;

  logic [1:0]       ctrlSelQ;
  logic             setUpStartQ;
  logic             charGenGrantQ;
  logic             readyQ;
  logic [1:0]       ctrlSelD;
  logic             setUpStartD;
  logic             charGenGrantD;
  logic             readyD;
`ifdef LCD_SEQ_TIMEOUT_EN
  logic             wdFire;
  logic             timeoutErrQ;
`endif

  // One counter serves every timed state; it restarts on each state change.
  lcd_seq_delay_cnt #(
    .WIDTH (CNT_W)
  ) uDelayCnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (nextState != state),
    .en      (cntEn),
    .limit   (cntLimit),
    .expired (cntExpired)
  );

  always_comb begin
    cntEn    = 1'b0;
    cntLimit = '0;
    case (state)
      POWERUP: begin
        cntEn    = 1'b1;
        cntLimit = PWR_LIM;
      end
      GAP: begin
        cntEn    = 1'b1;
        cntLimit = GAP_LIM;
      end
`ifdef LCD_SEQ_TIMEOUT_EN
      SETUP, GRANT: begin
        cntEn    = 1'b1;
        cntLimit = WD_LIM;
      end
`endif
      default: begin
        cntEn    = 1'b0;
        cntLimit = '0;
      end
    endcase
  end

  // Next state. A matching done wins over a watchdog expiry in the same cycle.
  always_comb begin
    nextState = state;
    setPend   = 1'b0;
    clrPend   = 1'b0;
`ifdef LCD_SEQ_TIMEOUT_EN
    wdFire    = 1'b0;
`endif
    case (state)
      POWERUP: begin
        if (cntExpired) nextState = SETUP;
      end
      SETUP: begin
        if (bus.setUpDone) begin
          nextState = READY;
        end
`ifdef LCD_SEQ_TIMEOUT_EN
        else if (cntExpired) begin
          nextState = POWERUP;
          wdFire    = 1'b1;
        end
`endif
      end
      READY: begin
        if (bus.reInit || pendReInit) begin
          nextState = SETUP;
          clrPend   = 1'b1;
        end else if (bus.charGenReq) begin
          nextState = GRANT;
        end
      end
      GRANT: begin
        // A command in flight is never aborted; remember reInit for later.
        setPend = bus.reInit;
        if (bus.charGenDone) begin
          nextState = GAP;
        end
`ifdef LCD_SEQ_TIMEOUT_EN
        else if (cntExpired) begin
          nextState = POWERUP;
          wdFire    = 1'b1;
        end
`endif
      end
      GAP: begin
        setPend = bus.reInit;
        if (cntExpired) nextState = READY;
      end
      default: nextState = POWERUP;
    endcase
  end

  // Registered outputs are a function of the state being entered. ctrlSel
  // stays on the char-gen source through GAP so its last value is held.
  always_comb begin
    ctrlSelD      = SEL_SETUP;
    setUpStartD   = 1'b0;
    charGenGrantD = 1'b0;
    readyD        = 1'b0;
    if (nextState == GRANT || nextState == GAP) ctrlSelD = SEL_CHARGEN;
    if (nextState == SETUP && state != SETUP)   setUpStartD = 1'b1;
    if (nextState == GRANT)                     charGenGrantD = 1'b1;
    if (nextState == READY)                     readyD = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= POWERUP;
      pendReInit    <= 1'b0;
      ctrlSelQ      <= SEL_SETUP;
      setUpStartQ   <= 1'b0;
      charGenGrantQ <= 1'b0;
      readyQ        <= 1'b0;
    end else begin
      state         <= nextState;
      if (clrPend) begin
        pendReInit <= 1'b0;
      end else if (setPend) begin
        pendReInit <= 1'b1;
      end
      ctrlSelQ      <= ctrlSelD;
      setUpStartQ   <= setUpStartD;
      charGenGrantQ <= charGenGrantD;
      readyQ        <= readyD;
    end
  end

`ifdef LCD_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeoutErrQ <= 1'b0;
    end else if (wdFire) begin
      timeoutErrQ <= 1'b1;
    end
  end

  assign bus.timeoutErr = timeoutErrQ;
`endif

  assign bus.ctrlSel      = ctrlSelQ;
  assign bus.setUpStart   = setUpStartQ;
  assign bus.charGenGrant = charGenGrantQ;
  assign bus.ready        = readyQ;
  assign dbgState         = state;

endmodule

// File: tb/tb_lcd_ctrl_sequencer.sv
// tb_lcd_ctrl_sequencer
// Cycle-accurate trace bench for lcd_ctrl_sequencer with POWERUP_CYCLES=4,
// GAP_CYCLES=2, TIMEOUT_CYCLES=8. Each driven cycle pushes the output vector
// {ctrlSel, setUpStart, charGenGrant, ready, timeoutErr} expected in that
// cycle; a negedge monitor pops and compares it.
module tb_lcd_ctrl_sequencer;
  import lcd_seq_pkg::*;

  localparam int W = 6;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  seqState_t dbgState;
  int        checks = 0;
  int        errors = 0;
  logic      teExp = 1'b0;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  logic [W-1:0] obsVec;
  logic         toObs;

  lcd_ctrl_sequencer_if bus();

  // clock / reset block
  always #5 clk = ~clk;

  lcd_ctrl_sequencer #(
    .POWERUP_CYCLES (4),
    .GAP_CYCLES     (2)
`ifdef LCD_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES (8)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbgState (dbgState)
  );

`ifdef LCD_SEQ_TIMEOUT_EN
  assign toObs = bus.timeoutErr;
`else
  assign toObs = 1'b0;
`endif
  assign obsVec = {bus.ctrlSel, bus.setUpStart, bus.charGenGrant, bus.ready, toObs};

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // expected output vectors
  function automatic logic [W-1:0] ov(input logic [1:0] sel, input logic st,
                                      input logic gr, input logic rd);
    return {sel, st, gr, rd, teExp};
  endfunction
  function automatic logic [W-1:0] zeroV();  return ov(SEL_SETUP,   1'b0, 1'b0, 1'b0); endfunction
  function automatic logic [W-1:0] startV(); return ov(SEL_SETUP,   1'b1, 1'b0, 1'b0); endfunction
  function automatic logic [W-1:0] rdyV();   return ov(SEL_SETUP,   1'b0, 1'b0, 1'b1); endfunction
  function automatic logic [W-1:0] gntV();   return ov(SEL_CHARGEN, 1'b0, 1'b1, 1'b0); endfunction
  function automatic logic [W-1:0] gapV();   return ov(SEL_CHARGEN, 1'b0, 1'b0, 1'b0); endfunction

  // driver: wait for the next edge, apply {setUpDone, charGenReq, charGenDone,
  // reInit} for this cycle and record the outputs expected in this cycle
  task automatic step(input logic [3:0] in, input logic [W-1:0] e, input string tag);
    @(posedge clk);
    #1;
    bus.setUpDone   = in[3];
    bus.charGenReq  = in[2];
    bus.charGenDone = in[1];
    bus.reInit      = in[0];
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    string        t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checkVal(t, 32'(obsVec), 32'(e));
    end
  end

  // cycles 1..7 after reset release; inputs in POWERUP must be ignored
  task automatic startUp();
    for (int i = 1; i <= 3; i++) step(4'b1111, zeroV(), "pwrIgnore");
    step(4'b0000, zeroV(),  "pwrLast");
    step(4'b0000, startV(), "setUpStart");
    step(4'b0000, zeroV(),  "setUpWait");
    step(4'b1000, zeroV(),  "setUpDoneIn");
  endtask

  // SETUP entered this cycle; reInit alongside setUpDone must be dropped,
  // which the caller's next READY expectation confirms
  task automatic setupSeq();
    step(4'b0000, startV(), "setUpStart");
    step(4'b1001, zeroV(),  "setUpDoneRi");
    step(4'b0000, rdyV(),   "readyAfterSetUp");
  endtask

  // one command: request in READY, done in the last grant cycle
  task automatic grantCmd(input int hold);
    step(4'b0100, rdyV(), "rdyReq");
    for (int k = 1; k <= hold; k++) step((k == hold) ? 4'b0010 : 4'b0000, gntV(), "grant");
    step(4'b0010, gapV(), "gapDoneIgnored");
    step(4'b0100, gapV(), "gapReqIgnored");
  endtask

  task automatic grantReInit();
    step(4'b0100, rdyV(), "rdyReq");
    step(4'b0001, gntV(), "grantReInit");
    step(4'b0010, gntV(), "grantDone");
    step(4'b0000, gapV(), "gapAfterRi");
    step(4'b0000, gapV(), "gapAfterRi");
    step(4'b0000, rdyV(), "rdyOneCycle");
    setupSeq();
  endtask

`ifdef LCD_SEQ_TIMEOUT_EN
  task automatic timeoutSeq();
    step(4'b0100, rdyV(), "rdyReqTo");
    for (int i = 0; i < 8; i++) step(4'b0000, gntV(), "grantNoDone");
    teExp = 1'b1;
    for (int i = 0; i < 5; i++) step(4'b0101, zeroV(), "toPowerUp");
    setupSeq();
  endtask
`endif

  initial begin
    int n;
    bus.setUpDone   = 1'b0;
    bus.charGenReq  = 1'b0;
    bus.charGenDone = 1'b0;
    bus.reInit      = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rstOut",   32'(obsVec),   32'(0));
    checkVal("rstState", 32'(dbgState), 32'(POWERUP));
    @(posedge clk);
    #1 rst = 1'b0;

    startUp();
    grantCmd(3);
    step(4'b0000, rdyV(), "idle");
    step(4'b0101, rdyV(), "rdyBoth");
    setupSeq();
    grantReInit();

    repeat (6) begin
      n = int'($urandom_range(2, 0));
      repeat (n) step(4'b0000, rdyV(), "idle");
      grantCmd(int'($urandom_range(5, 1)));
    end

    // asynchronous reset in the middle of a grant
    step(4'b0100, rdyV(), "rdyReqRst");
    step(4'b0000, gntV(), "grantPreRst");
    step(4'b0000, gntV(), "grantPreRst");
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkVal("asyncRstOut",   32'(obsVec),   32'(0));
    checkVal("asyncRstState", 32'(dbgState), 32'(POWERUP));
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    startUp();
    grantCmd(1);

`ifdef LCD_SEQ_TIMEOUT_EN
    timeoutSeq();
`endif
    grantCmd(2);
    step(4'b0000, rdyV(), "finalIdle");

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checkVal("queueDrained", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
